// File: rtl/mwc_pkg.sv
// Shared types and helpers for the mem_write_checker store monitor.
package mwc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TMO  = 3'd4
    } state_e;

    localparam logic CFG_SEL_EXP = 1'b0;
    localparam logic CFG_SEL_IGN = 1'b1;

    // Index width for the larger of two tables, never narrower than one bit.
    function automatic int clog2max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mwc_match.sv
// Combinational comparison of one store against the expected and ignore tables.
module mwc_match
    import mwc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_EXP  = 4,
    parameter int N_IGN  = 2
) (
    input  logic [ADDR_W-1:0]             dataadr,
    input  logic [DATA_W-1:0]             writedata,
    input  logic [N_EXP-1:0][ADDR_W-1:0]  exp_addr,
    input  logic [N_EXP-1:0][DATA_W-1:0]  exp_data,
    input  logic [N_EXP-1:0]              exp_en,
    input  logic [N_IGN-1:0][ADDR_W-1:0]  ign_addr,
    input  logic [N_IGN-1:0]              ign_valid,
    output logic                          exp_hit,
    output logic [clog2max(N_EXP, 1)-1:0] exp_hit_idx,
    output logic                          ign_hit
);

    localparam int EIDX_W = clog2max(N_EXP, 1);

    always_comb begin
        // NOTE: every output gets a default before the loops, so no path can infer a latch.
        exp_hit     = 1'b0;
        exp_hit_idx = '0;
        ign_hit     = 1'b0;
        // Walk downwards so the lowest eligible index wins.
        for (int i = N_EXP - 1; i >= 0; i--) begin
            if (exp_en[i] && exp_addr[i] == dataadr && exp_data[i] == writedata) begin
                exp_hit     = 1'b1;
                exp_hit_idx = EIDX_W'(i);
            end
        end
        for (int i = 0; i < N_IGN; i++) begin
            if (ign_valid[i] && ign_addr[i] == dataadr) begin
                ign_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Data-memory store monitor: checks stores against a programmable table and reports pass/fail/timeout.
// Optional MEM_WRITE_CHECKER_UNORDERED_EN lets expected entries match in any order.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int N_EXP       = 4,
    parameter int N_IGN       = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              memwrite,
    input  logic [ADDR_W-1:0]                 dataadr,
    input  logic [DATA_W-1:0]                 writedata,
    input  logic                              cfg_we,
    input  logic                              cfg_sel,
    input  logic [clog2max(N_EXP, N_IGN)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]                 cfg_addr,
    input  logic [DATA_W-1:0]                 cfg_data,
    input  logic [$clog2(N_EXP+1)-1:0]        cfg_num,
    input  logic                              arm,
    input  logic                              clear,
    output logic [2:0]                        state_o,
    output logic                              done,
    output logic                              pass,
    output logic                              fail,
    output logic                              timeout,
    output logic [$clog2(N_EXP+1)-1:0]        match_cnt,
    output logic [ADDR_W-1:0]                 fail_addr,
    output logic [DATA_W-1:0]                 fail_data,
    output logic [31:0]                       cyc_cnt
);

    localparam int          CNT_W    = $clog2(N_EXP + 1);
    localparam int          IDX_W    = clog2max(N_EXP, N_IGN);
    localparam int          EIDX_W   = clog2max(N_EXP, 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    state_e                      state_q, state_d;
    logic [N_EXP-1:0][ADDR_W-1:0] exp_addr_q;
    logic [N_EXP-1:0][DATA_W-1:0] exp_data_q;
    logic [N_IGN-1:0][ADDR_W-1:0] ign_addr_q;
    logic [N_IGN-1:0]             ign_valid_q;
    logic [CNT_W-1:0]             num_armed_q, num_clamped, match_cnt_q, cnt_inc;
    logic [31:0]                  cyc_cnt_q;
    logic                         st_mw_q;
    logic [ADDR_W-1:0]            st_adr_q;
    logic [DATA_W-1:0]            st_wd_q;
    logic [N_EXP-1:0]             exp_en;
    logic                         exp_hit, ign_hit;
    logic [EIDX_W-1:0]            exp_hit_idx;
    logic                         store_hit, store_done, store_fail, tmo_due;
`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
    logic [N_EXP-1:0]             hit_q;
`endif

    assign num_clamped = (int'(cfg_num) > N_EXP) ? CNT_W'(N_EXP) : cfg_num;

    always_comb begin
        exp_en = '0;
        for (int i = 0; i < N_EXP; i++) begin
`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
            exp_en[i] = (CNT_W'(i) < num_armed_q) && !hit_q[i];
`else
            exp_en[i] = (CNT_W'(i) == match_cnt_q);
`endif
        end
    end

    mwc_match #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_EXP  (N_EXP),
        .N_IGN  (N_IGN)
    ) u_match (
        .dataadr     (st_adr_q),
        .writedata   (st_wd_q),
        .exp_addr    (exp_addr_q),
        .exp_data    (exp_data_q),
        .exp_en      (exp_en),
        .ign_addr    (ign_addr_q),
        .ign_valid   (ign_valid_q),
        .exp_hit     (exp_hit),
        .exp_hit_idx (exp_hit_idx),
        .ign_hit     (ign_hit)
    );

`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
    assign cnt_inc = match_cnt_q + CNT_W'(1);
`else
    // The pointer advances past whichever entry matched, which is always match_cnt_q.
    assign cnt_inc = CNT_W'(exp_hit_idx) + CNT_W'(1);
`endif

    assign store_hit  = st_mw_q && exp_hit;
    assign store_done = store_hit && (cnt_inc == num_armed_q);
    assign store_fail = st_mw_q && !exp_hit && !ign_hit;
    assign tmo_due    = (TIMEOUT_CYC != 0) && (cyc_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:            if (arm) state_d = (num_clamped == '0) ? PASS : RUN;
            RUN: begin
                if      (store_done) state_d = PASS;
                else if (store_fail) state_d = FAIL;
                else if (tmo_due)    state_d = TMO;
            end
            PASS, FAIL, TMO: if (clear) state_d = IDLE;
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        pass    = (state_q == PASS);
        fail    = (state_q == FAIL);
        timeout = (state_q == TMO);
        done    = pass || fail || timeout;
        state_o = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tables are small flop arrays with no RAM behind them, so they reset like any other state.
            exp_addr_q  <= '0;
            exp_data_q  <= '0;
            ign_addr_q  <= '0;
            ign_valid_q <= '0;
            num_armed_q <= '0;
            match_cnt_q <= '0;
            cyc_cnt_q   <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            st_mw_q     <= 1'b0;
            st_adr_q    <= '0;
            st_wd_q     <= '0;
`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
            hit_q       <= '0;
`endif
        end else begin
            // Stores are registered before comparison; only those seen in RUN are kept.
            st_mw_q  <= memwrite && (state_q == RUN);
            st_adr_q <= dataadr;
            st_wd_q  <= writedata;

            if (state_q == IDLE && cfg_we) begin
                for (int i = 0; i < N_EXP; i++) begin
                    if (cfg_sel == CFG_SEL_EXP && cfg_idx == IDX_W'(i)) begin
                        exp_addr_q[i] <= cfg_addr;
                        exp_data_q[i] <= cfg_data;
                    end
                end
                for (int i = 0; i < N_IGN; i++) begin
                    if (cfg_sel == CFG_SEL_IGN && cfg_idx == IDX_W'(i)) begin
                        ign_addr_q[i]  <= cfg_addr;
                        ign_valid_q[i] <= 1'b1;
                    end
                end
            end

            unique case (state_q)
                IDLE: if (arm) num_armed_q <= num_clamped;
                RUN: begin
                    if (cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 32'd1;
                    if (store_hit) begin
                        match_cnt_q <= cnt_inc;
`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
                        hit_q[exp_hit_idx] <= 1'b1;
`endif
                    end else if (store_fail) begin
                        fail_addr <= st_adr_q;
                        fail_data <= st_wd_q;
                    end
                end
                PASS, FAIL, TMO: begin
                    if (clear) begin
                        num_armed_q <= '0;
                        match_cnt_q <= '0;
                        cyc_cnt_q   <= '0;
                        fail_addr   <= '0;
                        fail_data   <= '0;
`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
                        hit_q       <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign match_cnt = match_cnt_q;
    assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker (TIMEOUT_CYC = 50).
module tb_mem_write_checker;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TMO  = 3'd4;

    logic        clk, rst, memwrite, cfg_we, cfg_sel, arm, clear;
    logic [31:0] dataadr, writedata, cfg_addr, cfg_data;
    logic [1:0]  cfg_idx;
    logic [2:0]  cfg_num;
    logic [2:0]  state_o, match_cnt;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_addr, fail_data, cyc_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_write_checker #(.TIMEOUT_CYC(50)) dut (
        .clk       (clk),
        .rst       (rst),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_num   (cfg_num),
        .arm       (arm),
        .clear     (clear),
        .state_o   (state_o),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .match_cnt (match_cnt),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .cyc_cnt   (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] st,
                               input logic p, input logic f, input logic t);
        check({tag, ".state"}, state_o, st);
        check({tag, ".pass"}, pass, p);
        check({tag, ".fail"}, fail, f);
        check({tag, ".timeout"}, timeout, t);
        check({tag, ".done"}, done, p | f | t);
    endtask

    task automatic cfg_write(input logic sel, input logic [1:0] idx,
                             input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic arm_with(input logic [2:0] n);
        cfg_num = n; arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        cfg_num = '0; arm = 1'b0; clear = 1'b0;
        step(); step();
        rst = 1'b0;
        check_flags("reset", S_IDLE, 0, 0, 0);
        check("reset.match_cnt", match_cnt, 0);
        check("reset.fail_addr", fail_addr, 0);
        check("reset.cyc_cnt", cyc_cnt, 0);

        cfg_write(1'b0, 2'd0, 32'd84, 32'd7);
        cfg_write(1'b0, 2'd1, 32'd88, 32'd12);
        cfg_write(1'b1, 2'd0, 32'd80, 32'd0);

        // Ordered pass with interleaved ignored stores.
        arm_with(3'd2);
        check_flags("arm", S_RUN, 0, 0, 0);
        store(32'd80, 32'd3);
        store(32'd84, 32'd7);
        store(32'd80, 32'd1);
        store(32'd88, 32'd12);
        check_flags("pass.pre", S_RUN, 0, 0, 0);
        check("pass.pre.match_cnt", match_cnt, 1);
        step();
        check_flags("pass", S_PASS, 1, 0, 0);
        check("pass.match_cnt", match_cnt, 2);
        check("pass.cyc_cnt", cyc_cnt, 5);
        store(32'd92, 32'd5);
        step();
        arm_with(3'd2);
        check_flags("pass.hold", S_PASS, 1, 0, 0);
        check("pass.hold.fail_addr", fail_addr, 0);

        do_clear();
        check_flags("clear1", S_IDLE, 0, 0, 0);
        check("clear1.match_cnt", match_cnt, 0);
        check("clear1.cyc_cnt", cyc_cnt, 0);

        // Mismatch after one good store; captured values then freeze.
        arm_with(3'd2);
        store(32'd84, 32'd7);
        store(32'd92, 32'd5);
        step();
        check_flags("mism", S_FAIL, 0, 1, 0);
        check("mism.fail_addr", fail_addr, 92);
        check("mism.fail_data", fail_data, 5);
        check("mism.match_cnt", match_cnt, 1);
        store(32'd96, 32'd9);
        step();
        check("mism.frozen_addr", fail_addr, 92);
        check("mism.frozen_data", fail_data, 5);
        do_clear();

        // Timeout with no stores.
        arm_with(3'd2);
        repeat (49) step();
        check_flags("tmo.pre", S_RUN, 0, 0, 0);
        check("tmo.pre.cyc_cnt", cyc_cnt, 49);
        step();
        check_flags("tmo", S_TMO, 0, 0, 1);
        check("tmo.cyc_cnt", cyc_cnt, 50);
        do_clear();
        check_flags("tmo.clear", S_IDLE, 0, 0, 0);
        check("tmo.clear.cyc_cnt", cyc_cnt, 0);

        // Final store evaluated on the timeout cycle wins over TMO.
        arm_with(3'd2);
        store(32'd84, 32'd7);
        repeat (47) step();
        store(32'd88, 32'd12);
        check_flags("coll.pre", S_RUN, 0, 0, 0);
        check("coll.pre.cyc_cnt", cyc_cnt, 49);
        step();
        check_flags("coll", S_PASS, 1, 0, 0);
        check("coll.match_cnt", match_cnt, 2);
        check("coll.cyc_cnt", cyc_cnt, 50);
        do_clear();

        arm_with(3'd0);
        check_flags("num0", S_PASS, 1, 0, 0);
        check("num0.cyc_cnt", cyc_cnt, 0);
        do_clear();

        // Table writes during RUN must be dropped.
        arm_with(3'd2);
        cfg_write(1'b0, 2'd0, 32'd84, 32'd99);
        cfg_write(1'b1, 2'd1, 32'd92, 32'd0);
        store(32'd84, 32'd7);
        store(32'd88, 32'd12);
        step();
        check_flags("cfgrun", S_PASS, 1, 0, 0);
        check("cfgrun.match_cnt", match_cnt, 2);
        do_clear();

        arm_with(3'd2);
        store(32'd84, 32'd7);
        store(32'd92, 32'd5);
        step();
        check_flags("rearm", S_FAIL, 0, 1, 0);
        check("rearm.fail_addr", fail_addr, 92);
        check("rearm.fail_data", fail_data, 5);
        do_clear();

        // Unwritten ignore entry (address 0) is not valid.
        arm_with(3'd2);
        store(32'd0, 32'd0);
        step();
        check_flags("ignvalid", S_FAIL, 0, 1, 0);
        check("ignvalid.match_cnt", match_cnt, 0);
        do_clear();

        // Out-of-order stores.
        arm_with(3'd2);
        store(32'd88, 32'd12);
        store(32'd84, 32'd7);
        step();
`ifdef MEM_WRITE_CHECKER_UNORDERED_EN
        check_flags("order", S_PASS, 1, 0, 0);
        check("order.match_cnt", match_cnt, 2);
        do_clear();
        arm_with(3'd2);
        store(32'd88, 32'd12);
        store(32'd88, 32'd12);
        step();
        check_flags("dup", S_FAIL, 0, 1, 0);
        check("dup.fail_addr", fail_addr, 88);
        check("dup.match_cnt", match_cnt, 1);
`else
        check_flags("order", S_FAIL, 0, 1, 0);
        check("order.fail_addr", fail_addr, 88);
        check("order.fail_data", fail_data, 12);
        check("order.match_cnt", match_cnt, 0);
`endif
        do_clear();

        // Reset in RUN aborts and clears the tables.
        arm_with(3'd2);
        store(32'd84, 32'd7);
        step();
        check("rst.pre.match_cnt", match_cnt, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_flags("rst", S_IDLE, 0, 0, 0);
        check("rst.match_cnt", match_cnt, 0);
        check("rst.cyc_cnt", cyc_cnt, 0);
        check("rst.fail_addr", fail_addr, 0);

        // Cleared expected table is four (0,0) entries; cfg_num 7 clamps to 4.
        arm_with(3'd7);
        repeat (4) store(32'd0, 32'd0);
        check("clamp.pre.match_cnt", match_cnt, 3);
        step();
        check_flags("clamp", S_PASS, 1, 0, 0);
        check("clamp.match_cnt", match_cnt, 4);
        do_clear();

        arm_with(3'd1);
        store(32'd80, 32'd3);
        step();
        check_flags("ignclr", S_FAIL, 0, 1, 0);
        check("ignclr.fail_addr", fail_addr, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised self-check monitor that snoops the CPU data-memory write port (`memwrite`, `dataadr`, `writedata`).
- Compares each store against a programmable table of expected (address, data) pairs, plus a list of addresses to ignore. Reports pass, fail or timeout with captured diagnostics.
- Sits beside `top` in simulation benches and FPGA bring-up builds. Replaces the hard-coded single-store check with a multi-store, configurable one.

Parameters:
- ADDR_W, 32, width of `dataadr`
- DATA_W, 32, width of `writedata`
- N_EXP, 4, expected-table depth (>=1)
- N_IGN, 2, ignore-address table depth (>=1)
- TIMEOUT_CYC, 100000, cycles allowed in RUN before timeout; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active high
- memwrite  in  1  store strobe, one store per cycle when high
- dataadr  in  ADDR_W  store address
- writedata  in  DATA_W  store data
- cfg_we  in  1  table write strobe, honoured only in IDLE
- cfg_sel  in  1  0 = expected table, 1 = ignore table
- cfg_idx  in  $clog2(max(N_EXP,N_IGN))  entry index
- cfg_addr  in  ADDR_W  entry address
- cfg_data  in  DATA_W  entry data, unused for the ignore table
- cfg_num  in  $clog2(N_EXP+1)  number of valid expected entries, sampled on `arm`
- arm  in  1  IDLE -> RUN pulse
- clear  in  1  terminal state -> IDLE pulse
- state_o  out  3  encoded state
- done  out  1  in PASS, FAIL or TMO
- pass, fail, timeout  out  1 each  one-hot terminal status
- match_cnt  out  $clog2(N_EXP+1)  matched entries so far
- fail_addr  out  ADDR_W  address of the offending store
- fail_data  out  DATA_W  data of the offending store
- cyc_cnt  out  32  cycles spent in RUN, saturating

Behaviour:
- Reset: state IDLE; all status outputs 0; `match_cnt`, `fail_addr`, `fail_data`, `cyc_cnt` = 0; both tables cleared; ignore-valid bits 0.
- A `rst` asserted mid-operation aborts immediately with no report.
- Ignore entries become valid once written.
- States: IDLE -> (arm) RUN -> PASS | FAIL | TMO. Terminal states hold until `clear` or `rst`; `clear` returns to IDLE, zeroes status and counters, and keeps the table contents.
- IDLE: stores are ignored. If `arm` is sampled with `cfg_num` = 0, go straight to PASS on the next cycle. A `cfg_num` value above N_EXP is clamped to N_EXP.
- RUN, per cycle with `memwrite` = 1, evaluated in priority order:
  1. (`dataadr`, `writedata`) equals expected entry [`match_cnt`] -> increment `match_cnt`. If the new value equals the armed count -> PASS.
  2. Else `dataadr` matches any valid ignore entry -> no effect.
  3. Else -> FAIL, capturing `dataadr` / `writedata` into `fail_addr` / `fail_data`.
- Address and data comparisons are full-width equality; the comparison is fully registered. A store sampled on edge N is reflected on all outputs after edge N+1 (1-cycle latency).
- `cyc_cnt` increments every cycle in RUN and saturates at all ones.
- Timeout fires when TIMEOUT_CYC != 0 and `cyc_cnt` == TIMEOUT_CYC-1 with no other terminal transition that cycle. A store that completes or fails on the timeout cycle takes priority over TMO.
- `arm` outside IDLE, `clear` outside terminal states, and `cfg_we` outside IDLE are all ignored.
- Stores in terminal states are ignored; the captured values are frozen.

Optional Feature:
- Macro: MEM_WRITE_CHECKER_UNORDERED_EN.
- Defined: expected entries may match in any order. A per-entry hit bitmap replaces the index pointer. A store matches the lowest-index unhit valid entry with equal address and data, and sets its hit bit. `match_cnt` = popcount of the hits. PASS when all armed entries are hit. A store equal to an already-hit entry, and not ignored, -> FAIL.
- Undefined: strictly ordered matching as described above.

Decomposition:
- Package `mwc_pkg`: `state_e` enum (IDLE=0, RUN=1, PASS=2, FAIL=3, TMO=4), the `cfg_sel` constants, and a `clog2max` helper function.
- One sub-module, `mwc_match`: purely combinational comparison of one store against both tables. Outputs `exp_hit`, `exp_hit_idx` and `ign_hit`. Instantiated once.

Test Plan:
- Ordered pass: program exp = {(80,7)→no: (84,7),(88,12)}, cfg_num=2, ign={80}. Drive stores (80,3),(84,7),(80,1),(88,12) -> `pass`=1, `match_cnt`=2 one cycle after the last store.
- Mismatch: same table, drive (84,7) then (92,5) -> `fail`=1, `fail_addr`=92, `fail_data`=5, `match_cnt`=1.
- Timeout: TIMEOUT_CYC=50, arm, no stores -> `timeout`=1 with `cyc_cnt`=50. Then `clear` -> IDLE with all status 0.
- Collision: the final expected store arrives exactly on the timeout cycle -> PASS, not TMO. `rst` asserted in RUN -> IDLE with all outputs 0 on the next cycle.
- Edge: `cfg_num`=0 with `arm` -> PASS after 1 cycle. `cfg_we` during RUN leaves the table unchanged; re-arming after `clear` reproduces the earlier result.
- Unordered build: exp {(84,7),(88,12)}, stores (88,12),(84,7) -> PASS. Stores (88,12),(88,12) -> FAIL with `fail_addr`=88.
